// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the accumulator CPU bus: DATA_W x 2**ADDR_W word store
// serving direct and one-level indirect CPU accesses, plus a program-load port.
module cpu_mem_responder #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_mem,
  input  logic [ADDR_W-1:0] addr,
  input  logic              wr,
  input  logic              addr_mode,
  input  logic [DATA_W-1:0] data_in,
  input  logic              req_valid,
  output logic              req_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              rsp_valid,
  output logic              busy,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ack
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_IND  = 1'b1
  } state_t;

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  state_t            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic              wr_lat_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] data_out_q;
  logic              rsp_valid_q;
  logic              load_ack_q;

  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_waddr_s;
  logic [DATA_W-1:0] mem_wdata_s;
  logic              accept_s;
  logic [DATA_W-1:0] rd_word_s;

  assign req_ready = (state_q == ST_IDLE) && !load_en;
  assign accept_s  = req_valid && req_ready;
  assign rd_word_s = mem_q[addr];

  assign data_out  = data_out_q;
  assign rsp_valid = rsp_valid_q;
  assign load_ack  = load_ack_q;
  assign busy      = (state_q != ST_IDLE);

  // Single write port: reset suppresses every write, IND owns the port, then loader, then CPU.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_waddr_s = load_addr;
    mem_wdata_s = load_data;
    if (rst_mem) begin
      mem_we_s = 1'b0;
    end else if (state_q == ST_IND) begin
      mem_we_s    = wr_lat_q;
      mem_waddr_s = ptr_q;
      mem_wdata_s = wdata_q;
    end else if (load_en) begin
      mem_we_s = 1'b1;
    end else if (accept_s && !addr_mode && wr) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = addr;
      mem_wdata_s = data_in;
    end else begin
      mem_we_s = 1'b0;
    end
  end

  // Word store; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[mem_waddr_s] <= mem_wdata_s;
    end
  end

  // Request FSM with registered response, ack and pointer state.
  always_ff @(posedge clk) begin
    if (rst_mem) begin
      state_q     <= ST_IDLE;
      ptr_q       <= {ADDR_W{1'b0}};
      wr_lat_q    <= 1'b0;
      wdata_q     <= {DATA_W{1'b0}};
      data_out_q  <= {DATA_W{1'b0}};
      rsp_valid_q <= 1'b0;
      load_ack_q  <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      load_ack_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (load_en) begin
            load_ack_q <= 1'b1;
          end else if (req_valid) begin
            if (addr_mode) begin
              // Only the low pointer bits form the effective address.
              ptr_q    <= rd_word_s[ADDR_W-1:0];
              wr_lat_q <= wr;
              wdata_q  <= data_in;
              state_q  <= ST_IND;
            end else begin
              data_out_q  <= wr ? data_in : rd_word_s;
              rsp_valid_q <= 1'b1;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_IND: begin
          data_out_q  <= wr_lat_q ? wdata_q : mem_q[ptr_q];
          rsp_valid_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Self-checking bench for cpu_mem_responder: directed scenarios followed by random
// traffic compared against a flat-array memory model.
module tb_cpu_mem_responder;

  localparam int AW = 10;
  localparam int DW = 16;
  localparam int DEPTH = 1024;

  logic          clk = 1'b0;
  logic          rst_mem;
  logic [AW-1:0] addr;
  logic          wr;
  logic          addr_mode;
  logic [DW-1:0] data_in;
  logic          req_valid;
  logic          req_ready;
  logic [DW-1:0] data_out;
  logic          rsp_valid;
  logic          busy;
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [DW-1:0] load_data;
  logic          load_ack;

  logic [DW-1:0] model [DEPTH];
  int checks = 0;
  int errors = 0;

  cpu_mem_responder #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_mem(rst_mem), .addr(addr), .wr(wr), .addr_mode(addr_mode),
    .data_in(data_in), .req_valid(req_valid), .req_ready(req_ready),
    .data_out(data_out), .rsp_valid(rsp_valid), .busy(busy),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .load_ack(load_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [AW-1:0] a, input logic [DW-1:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    #1;
    chk("load_req_ready", {31'd0, req_ready}, 32'd0);
    tick();
    load_en = 1'b0;
    model[a] = d;
    chk("load_ack", {31'd0, load_ack}, 32'd1);
  endtask

  task automatic cpu_req(input logic [AW-1:0] a, input logic w, input logic m, input logic [DW-1:0] d);
    logic [DW-1:0] exp;
    logic [AW-1:0] p;
    addr = a; wr = w; addr_mode = m; data_in = d; req_valid = 1'b1;
    #1;
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    p = m ? model[a][AW-1:0] : a;
    if (w) begin
      model[p] = d;
      exp = d;
    end else begin
      exp = model[p];
    end
    tick();
    req_valid = 1'b0;
    if (m) begin
      chk("ind_no_rsp_yet", {31'd0, rsp_valid}, 32'd0);
      chk("ind_busy", {31'd0, busy}, 32'd1);
      chk("ind_req_ready", {31'd0, req_ready}, 32'd0);
      tick();
    end else begin
    end
    chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("data_out", {16'd0, data_out}, {16'd0, exp});
    chk("busy_after", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst_mem = 1'b1; addr = '0; wr = 1'b0; addr_mode = 1'b0; data_in = '0;
    req_valid = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
    tick(); tick();
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_load_ack", {31'd0, load_ack}, 32'd0);
    chk("rst_data_out", {16'd0, data_out}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    rst_mem = 1'b0;

    // Fill the whole store so every model word is known.
    for (int i = 0; i < DEPTH; i++) begin
      do_load(i[AW-1:0], DW'($urandom));
    end

    do_load(10'd5, 16'h1234);
    cpu_req(10'd5, 1'b0, 1'b0, 16'h0000);
    chk("t2_data", {16'd0, data_out}, 32'h0000_1234);

    do_load(10'd10, 16'hFC07);
    do_load(10'd7, 16'hBEEF);
    cpu_req(10'd10, 1'b0, 1'b1, 16'h0000);
    chk("t3_data", {16'd0, data_out}, 32'h0000_BEEF);

    do_load(10'd3, 16'h0020);
    cpu_req(10'd3, 1'b1, 1'b1, 16'h5A5A);
    cpu_req(10'd32, 1'b0, 1'b0, 16'h0000);
    chk("t4_target", {16'd0, data_out}, 32'h0000_5A5A);
    cpu_req(10'd3, 1'b0, 1'b0, 16'h0000);
    chk("t4_ptr_kept", {16'd0, data_out}, 32'h0000_0020);

    cpu_req(10'd1023, 1'b1, 1'b0, 16'hFFFF);
    cpu_req(10'd1023, 1'b0, 1'b0, 16'h0000);
    chk("t5_raw", {16'd0, data_out}, 32'h0000_FFFF);

    // Loader and CPU collide in IDLE: loader wins, request goes the cycle after.
    load_en = 1'b1; load_addr = 10'd200; load_data = 16'hA5C3;
    addr = 10'd200; wr = 1'b0; addr_mode = 1'b0; req_valid = 1'b1;
    #1;
    chk("t6_ready_low", {31'd0, req_ready}, 32'd0);
    tick();
    load_en = 1'b0;
    model[200] = 16'hA5C3;
    chk("t6_ack", {31'd0, load_ack}, 32'd1);
    chk("t6_no_rsp", {31'd0, rsp_valid}, 32'd0);
    cpu_req(10'd200, 1'b0, 1'b0, 16'h0000);
    chk("t6_data", {16'd0, data_out}, 32'h0000_A5C3);

    // Reset while in IND abandons the indirect write.
    do_load(10'd40, 16'h0032);
    do_load(10'd50, 16'h1111);
    addr = 10'd40; wr = 1'b1; addr_mode = 1'b1; data_in = 16'h9999; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("t6r_busy", {31'd0, busy}, 32'd1);
    rst_mem = 1'b1;
    tick();
    rst_mem = 1'b0;
    chk("t6r_no_rsp", {31'd0, rsp_valid}, 32'd0);
    chk("t6r_idle", {31'd0, busy}, 32'd0);
    chk("t6r_dout", {16'd0, data_out}, 32'd0);
    tick();
    chk("t6r_no_rsp2", {31'd0, rsp_valid}, 32'd0);
    cpu_req(10'd50, 1'b0, 1'b0, 16'h0000);
    chk("t6r_unchanged", {16'd0, data_out}, 32'h0000_1111);

    // Self-referencing pointer: the indirect write overwrites the pointer word.
    do_load(10'd100, 16'h0064);
    cpu_req(10'd100, 1'b1, 1'b1, 16'h7E57);
    cpu_req(10'd100, 1'b0, 1'b0, 16'h0000);
    chk("self_ptr", {16'd0, data_out}, 32'h0000_7E57);

    // Random mixed traffic, mostly back-to-back.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        do_load(AW'($urandom), DW'($urandom));
      end else begin
        cpu_req(AW'($urandom), 1'($urandom), 1'($urandom), DW'($urandom));
      end
      if ($urandom_range(0, 3) == 0) begin
        tick();
        chk("idle_no_rsp", {31'd0, rsp_valid}, 32'd0);
      end else begin
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
